// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch FSM with redirect/kill handling
// and a registered RV32 format classifier feeding the decode stage.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [2:0]  out_instr_type,
   output logic        out_illegal
);
   typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;
   state_t state, state_n;
   logic [31:0] pc, pc_n;
   logic kill, kill_n, cap, drop;
   logic [6:0] op;
   logic [2:0] typ;
   assign imem_req  = state == FETCH;
   assign imem_addr = pc;
   assign op        = imem_rdata[6:0];
   always_comb
      typ = op == 7'b0110011 ? 3'd0 :
            (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111 || op == 7'b1110011) ? 3'd1 :
            op == 7'b0100011 ? 3'd2 :
            op == 7'b1100011 ? 3'd3 :
            (op == 7'b0110111 || op == 7'b0010111) ? 3'd4 :
            op == 7'b1101111 ? 3'd5 : 3'd7;
   always_comb begin
      state_n = state;
      pc_n    = pc;
      kill_n  = kill;
      cap     = 1'b0;
      drop    = 1'b0;
      case (state)
         IDLE:  state_n = FETCH;
         FETCH: begin
            state_n = WAIT;
            kill_n  = redirect_valid;
         end
         WAIT:  if (imem_rvalid) begin
            // a redirect arriving with the response discards it just like a pending kill
            state_n = (kill || redirect_valid) ? FETCH : HOLD;
            cap     = !(kill || redirect_valid);
            kill_n  = 1'b0;
         end else
            kill_n = kill || redirect_valid;
         HOLD:  begin
            drop    = out_ready || redirect_valid;
            state_n = drop ? FETCH : HOLD;
            pc_n    = out_ready ? pc + 32'd4 : pc;
         end
      endcase
      if (redirect_valid && state != IDLE)
         pc_n = redirect_pc & 32'hFFFF_FFFC;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state          <= IDLE;
         pc             <= RESET_PC & 32'hFFFF_FFFC;
         kill           <= 1'b0;
         out_valid      <= 1'b0;
         out_instr      <= 32'h0000_0013;
         out_pc         <= RESET_PC;
         out_instr_type <= 3'd1;
         out_illegal    <= 1'b0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         kill      <= kill_n;
         out_valid <= cap || (out_valid && !drop);
         if (cap) begin
            out_instr      <= imem_rdata;
            out_pc         <= pc;
            out_instr_type <= typ;
            out_illegal    <= typ == 3'd7;
         end
      end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized memory/redirect/ready stimulus with a scoreboard of
// expected deliveries derived from fetch-address and discard rules.
module tb_instr_fetch;
   logic clk = 1'b0, rst_n = 1'b0;
   logic imem_req, imem_rvalid, redirect_valid, out_valid, out_ready, out_illegal;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc;
   logic [2:0] out_instr_type;
   always #5 clk = ~clk;
   instr_fetch dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_instr_type(out_instr_type), .out_illegal(out_illegal)
   );
   typedef struct {logic [31:0] pc; logic [31:0] instr; logic [2:0] typ;} item_t;
   item_t q[$];
   logic [31:0] data_q[$];
   logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
                            7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
   logic [2:0] tys [10] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5};
   int checks = 0, errors = 0, delivered = 0;
   int lat_min = 1, lat_max = 1, rdy_pct = 100, redir_pct = 0;
   bit redir_req = 0, gap_chk = 0, outstanding = 0;
   logic [31:0] redir_tgt = 0;
   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", n, act, exp);
      end
   endtask
   function automatic logic [2:0] ref_type(logic [31:0] w);
      for (int i = 0; i < 10; i++)
         if (w[6:0] == ops[i]) return tys[i];
      return 3'd7;
   endfunction
   function automatic logic [31:0] rand_word();
      logic [31:0] w = $urandom;
      if ($urandom_range(3, 0) != 0) w[6:0] = ops[$urandom_range(9, 0)];
      return w;
   endfunction
   // memory, ready and redirect driver plus the reference model
   initial begin
      int cnt = 0, cyc = 0, last_req = -1;
      bit rv, redir, rdy, tainted = 0;
      logic [31:0] exp_pc = 0, req_addr = 0, d = 0, tgt;
      imem_rvalid = 0; imem_rdata = 0; redirect_valid = 0; redirect_pc = 0; out_ready = 0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         if (!rst_n) begin
            outstanding = 0; q.delete(); exp_pc = 0; last_req = -1;
            imem_rvalid = 0; redirect_valid = 0; out_ready = 0;
            continue;
         end
         rv = 0;
         if (imem_req) begin
            chk("req_addr", imem_addr, exp_pc);
            chk("one_outstanding", 32'(outstanding), 0);
            chk("no_req_in_hold", 32'(out_valid), 0);
            if (gap_chk && last_req >= 0) chk("throughput_gap", 32'(cyc - last_req), 3);
            last_req = cyc; outstanding = 1; tainted = 0; req_addr = exp_pc;
            cnt = $urandom_range(lat_max, lat_min);
         end else if (outstanding) begin
            cnt--;
            rv = cnt == 0;
         end
         redir = redir_req || ($urandom_range(99, 0) < redir_pct);
         tgt = redir_req ? redir_tgt : ($urandom_range(1, 0) ? $urandom : 32'($urandom_range(255, 0)));
         redir_req = 0;
         rdy = $urandom_range(99, 0) < rdy_pct;
         if (redir && outstanding) tainted = 1;
         if (rv) begin
            d = data_q.size() != 0 ? data_q.pop_front() : rand_word();
            outstanding = 0;
            if (!tainted) q.push_back('{req_addr, d, ref_type(d)});
         end
         if (redir) exp_pc = tgt & 32'hFFFF_FFFC;
         else if (out_valid && rdy) exp_pc += 4;
         imem_rvalid = rv; imem_rdata = rv ? d : $urandom;
         redirect_valid = redir; redirect_pc = redir ? tgt : $urandom;
         out_ready = rdy;
      end
   end
   // monitor: every presented instruction must match the scoreboard head
   initial forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
         if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_valid actual=out_valid pc=%h required=no_instruction", out_pc);
         end else begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_instr", out_instr, q[0].instr);
            chk("out_type", 32'(out_instr_type), 32'(q[0].typ));
            chk("out_illegal", 32'(out_illegal), 32'(q[0].typ == 3'd7));
            if (out_ready || redirect_valid) void'(q.pop_front());
            if (out_ready) delivered++;
         end
      end
   end
   task automatic wait_deliv(int n, int budget);
      int t = 0;
      while (delivered < n && t < budget) begin @(negedge clk); t++; end
      chk("delivery_timeout", 32'(delivered >= n), 1);
   endtask
   task automatic wait_valid(int budget);
      int t = 0;
      while (!out_valid && t < budget) begin @(negedge clk); t++; end
      chk("valid_timeout", 32'(out_valid), 1);
   endtask
   task automatic wait_wait_state(int budget);
      int t = 0;
      while (!(outstanding && !imem_req) && t < budget) begin @(negedge clk); t++; end
      chk("wait_state_timeout", 32'(outstanding && !imem_req), 1);
   endtask
   task automatic wait_req(int budget);
      int t = 0;
      @(negedge clk);
      while (!imem_req && t < budget) begin @(negedge clk); t++; end
      chk("req_timeout", 32'(imem_req), 1);
   endtask
   task automatic chk_reset(string tag);
      chk({tag, "_imem_req"}, 32'(imem_req), 0);
      chk({tag, "_imem_addr"}, imem_addr, 0);
      chk({tag, "_out_valid"}, 32'(out_valid), 0);
      chk({tag, "_out_instr"}, out_instr, 32'h0000_0013);
      chk({tag, "_out_pc"}, out_pc, 0);
      chk({tag, "_out_type"}, 32'(out_instr_type), 1);
      chk({tag, "_out_illegal"}, 32'(out_illegal), 0);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      chk_reset("reset");
      data_q.push_back(32'h0050_0093);
      rst_n = 1;
      @(negedge clk);
      chk("first_req", 32'(imem_req), 1);
      chk("first_addr", imem_addr, 0);
      wait_deliv(1, 50);
      gap_chk = 1;
      foreach (ops[i]) if (i < 0) data_q.push_back(0);
      data_q.push_back(32'h0020_81B3); data_q.push_back(32'h0011_2023);
      data_q.push_back(32'hFE00_0EE3); data_q.push_back(32'h1234_52B7);
      data_q.push_back(32'h0000_006F);
      wait_deliv(6, 100);
      gap_chk = 0;
      rdy_pct = 0;
      wait_valid(50);
      repeat (5) @(negedge clk);
      rdy_pct = 100;
      data_q.push_back(32'hFFFF_FFFF); data_q.push_back(32'h0000_0000);
      wait_deliv(delivered + 3, 100);
      for (int l = 2; l <= 3; l++) begin
         lat_min = l; lat_max = l;
         wait_wait_state(50);
         redir_tgt = 32'h0000_0102; redir_req = 1;
         wait_req(50);
         chk("redirect_addr", imem_addr, 32'h0000_0100);
      end
      lat_min = 1; lat_max = 1;
      rdy_pct = 0;
      wait_valid(50);
      redir_tgt = 32'hFFFF_FFFE; redir_req = 1;
      wait_req(50);
      chk("wrap_start_addr", imem_addr, 32'hFFFF_FFFC);
      rdy_pct = 100;
      wait_req(50);
      chk("wrap_addr", imem_addr, 32'h0000_0000);
      lat_min = 3; lat_max = 3;
      wait_wait_state(50);
      rst_n = 0;
      #1 chk_reset("midreset");
      @(negedge clk);
      rst_n = 1;
      wait_req(50);
      chk("post_reset_addr", imem_addr, 0);
      lat_min = 1; rdy_pct = 70; redir_pct = 5;
      repeat (2000) @(negedge clk);
      redir_pct = 0; rdy_pct = 100;
      wait_deliv(delivered + 3, 200);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
